// File: rtl/expr_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | expr_sweep_ctrl : exhaustive operand sweep, DUT-vs-reference comparator   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module expr_sweep_ctrl #(
   parameter int unsigned A_WIDTH = 4,
   parameter int unsigned Y_WIDTH = 16,
   parameter int unsigned SETTLE  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_on_fail_i,
   input  logic [Y_WIDTH-1:0] y_dut_i,
   input  logic [Y_WIDTH-1:0] y_ref_i,
   output logic [A_WIDTH-1:0] a_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               pass_o,
   output logic [A_WIDTH:0]   mismatch_count_o,
   output logic               fail_valid_o,
   output logic [A_WIDTH-1:0] fail_a_o,
   output logic [Y_WIDTH-1:0] fail_y_dut_o,
   output logic [Y_WIDTH-1:0] fail_y_ref_o
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_APPLY   = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [3:0]         C_SETTLE = 4'(SETTLE);
   localparam logic [A_WIDTH-1:0] C_A_ONE  = A_WIDTH'(1);
   localparam logic [A_WIDTH:0]   C_M_ONE  = (A_WIDTH+1)'(1);

   logic [1:0]         state_q, state_d;
   logic [A_WIDTH-1:0] a_q, a_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               stop_q, stop_d;
   logic [A_WIDTH:0]   mcount_q, mcount_d;
   logic               fv_q, fv_d;
   logic [A_WIDTH-1:0] fa_q, fa_d;
   logic [Y_WIDTH-1:0] fyd_q, fyd_d;
   logic [Y_WIDTH-1:0] fyr_q, fyr_d;

   logic mismatch;
   logic last_vec;

   assign mismatch = (y_dut_i != y_ref_i);
   assign last_vec = (a_q == {A_WIDTH{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         cnt_q    <= '0;
         stop_q   <= 1'b0;
         mcount_q <= '0;
         fv_q     <= 1'b0;
         fa_q     <= '0;
         fyd_q    <= '0;
         fyr_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         cnt_q    <= cnt_d;
         stop_q   <= stop_d;
         mcount_q <= mcount_d;
         fv_q     <= fv_d;
         fa_q     <= fa_d;
         fyd_q    <= fyd_d;
         fyr_q    <= fyr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      cnt_d    = cnt_q;
      stop_d   = stop_q;
      mcount_d = mcount_q;
      fv_d     = fv_q;
      fa_d     = fa_q;
      fyd_d    = fyd_q;
      fyr_d    = fyr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               a_d      = '0;
               cnt_d    = C_SETTLE;
               stop_d   = stop_on_fail_i;
               mcount_d = '0;
               fv_d     = 1'b0;
               fa_d     = '0;
               fyd_d    = '0;
               fyr_d    = '0;
               state_d  = S_APPLY;
            end
         end
         S_APPLY: begin
            if (cnt_q == 4'd0) begin
               state_d = S_COMPARE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_COMPARE: begin
            // Only the first failing vector is captured; later ones just count.
            if (mismatch) begin
               mcount_d = mcount_q + C_M_ONE;
               if (!fv_q) begin
                  fv_d  = 1'b1;
                  fa_d  = a_q;
                  fyd_d = y_dut_i;
                  fyr_d = y_ref_i;
               end
            end
            if ((mismatch && stop_q) || last_vec) begin
               state_d = S_DONE;
            end else begin
               a_d     = a_q + C_A_ONE;
               cnt_d   = C_SETTLE;
               state_d = S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == S_APPLY) || (state_q == S_COMPARE);
      done_o = (state_q == S_DONE);
      pass_o = (state_q == S_DONE) && (mcount_q == '0);
   end

   assign a_o              = a_q;
   assign mismatch_count_o = mcount_q;
   assign fail_valid_o     = fv_q;
   assign fail_a_o         = fa_q;
   assign fail_y_dut_o     = fyd_q;
   assign fail_y_ref_o     = fyr_q;

endmodule
`default_nettype wire
